// File: rtl/fetch_unit.sv
// Instruction fetch: one req/ack read per PC, result registered; 1-cycle minimum latency (2 cycles/instr zero-wait).
// Backpressure: fetch_stall holds the PC block while a read is outstanding; hold=1 parks the fetched instruction in READY.
module fetch_unit #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          TIMEOUT    = 255,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-3:0] pc,
    input  logic                  hold,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-3:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [31:0]           imem_rdata,
    input  logic                  imem_err,
    output logic [31:0]           instr,
    output logic [ADDR_WIDTH-3:0] instr_pc,
    output logic                  instr_valid,
    output logic                  instr_fault,
    output logic                  fetch_stall
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic {FETCH, READY} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          expire;

    assign expire    = (TIMEOUT != 0) && (count == CNT_LAST);
    // fetch_stall is a flop, so reset is the only combinational term on imem_req
    assign imem_req  = fetch_stall & ~reset;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            instr_fault <= 1'b0;
            fetch_stall <= 1'b1;
            count       <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instr       <= imem_err ? NOP_INSTR : imem_rdata;
                        instr_pc    <= pc;
                        instr_fault <= imem_err;
                        instr_valid <= 1'b1;
                        fetch_stall <= 1'b0;
                        state       <= READY;
                    end else if (expire) begin
                        instr       <= NOP_INSTR;
                        instr_pc    <= pc;
                        instr_fault <= 1'b1;
                        instr_valid <= 1'b1;
                        fetch_stall <= 1'b0;
                        state       <= READY;
                    end else if (TIMEOUT != 0) begin
                        count <= count + 1'b1;
                    end
                end
                READY: begin
                    if (!hold) begin
                        instr_valid <= 1'b0;
                        fetch_stall <= 1'b1;
                        count       <= '0;
                        state       <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit (TIMEOUT=4): directed vector table, reset corner cases, randomized transactions vs a transaction model.
module tb_fetch_unit;

    localparam int          TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [29:0] pc = '0;
    logic        hold = 1'b0;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        imem_err = 1'b0;
    logic [31:0] instr;
    logic [29:0] instr_pc;
    logic        instr_valid;
    logic        instr_fault;
    logic        fetch_stall;

    int checks = 0;
    int errors = 0;
    int cycles = 0;

    fetch_unit #(.ADDR_WIDTH(32), .TIMEOUT(TO), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .pc(pc), .hold(hold),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .imem_err(imem_err),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_fault(instr_fault), .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [29:0] pc;
        int          lat;
        bit          err;
        logic [31:0] data;
        int          hold_n;
        int          exp_reqs;
        logic [31:0] exp_instr;
        bit          exp_fault;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cycles);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        cycles++;
    endtask

    // Transaction-level expectation: ack latency L cycles after req rises, watchdog fires after TO request cycles.
    function automatic void model(input int lat, input bit e, input logic [31:0] d,
                                  output int reqs, output logic [31:0] ins, output bit flt);
        if (lat < TO) begin
            reqs = lat + 1;
            flt  = e;
        end else begin
            reqs = TO;
            flt  = 1'b1;
        end
        ins = flt ? NOP : d;
    endfunction

    // Entered on the first FETCH cycle; leaves on the first FETCH cycle of the next transaction.
    task automatic run_fetch(input logic [29:0] p, input int lat, input bit e, input logic [31:0] d,
                             input int hold_n, input int exp_reqs, input logic [31:0] exp_i, input bit exp_f);
        int reqs;
        reqs = 0;
        pc   = p;
        #1;
        while (imem_req && reqs < 64) begin
            chk("fetch_addr", 64'(imem_addr), 64'(p));
            chk("fetch_stall_hi", 64'(fetch_stall), 64'd1);
            chk("fetch_valid_lo", 64'(instr_valid), 64'd0);
            imem_ack   = (reqs == lat);
            imem_err   = imem_ack ? e : 1'($urandom);
            imem_rdata = imem_ack ? d : $urandom;
            hold       = 1'($urandom);
            reqs++;
            step();
        end
        chk("req_cycles", 64'(reqs), 64'(exp_reqs));
        for (int k = 0; k <= hold_n; k++) begin
            chk("ready_valid", 64'(instr_valid), 64'd1);
            chk("ready_instr", 64'(instr), 64'(exp_i));
            chk("ready_pc", 64'(instr_pc), 64'(p));
            chk("ready_fault", 64'(instr_fault), 64'(exp_f));
            chk("ready_req_lo", 64'(imem_req), 64'd0);
            chk("ready_stall_lo", 64'(fetch_stall), 64'd0);
            hold       = (k < hold_n);
            imem_ack   = 1'($urandom);
            imem_err   = 1'($urandom);
            imem_rdata = $urandom;
            step();
        end
        hold     = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        int          c0;
        int          er;
        logic [31:0] ei;
        bit          ef;
        int          lat;
        bit          e;
        logic [31:0] d;

        tbl[0] = '{30'h00, 0, 1'b0, 32'hA000_0000, 0, 1, 32'hA000_0000, 1'b0};
        tbl[1] = '{30'h01, 0, 1'b0, 32'hA000_0001, 0, 1, 32'hA000_0001, 1'b0};
        tbl[2] = '{30'h02, 0, 1'b0, 32'hA000_0002, 0, 1, 32'hA000_0002, 1'b0};
        tbl[3] = '{30'h10, 3, 1'b0, 32'h1234_5678, 0, 4, 32'h1234_5678, 1'b0};
        tbl[4] = '{30'h20, 0, 1'b1, 32'hDEAD_BEEF, 0, 1, NOP,           1'b1};
        tbl[5] = '{30'h21, 1, 1'b0, 32'h0BAD_F00D, 0, 2, 32'h0BAD_F00D, 1'b0};
        tbl[6] = '{30'h30, 9, 1'b0, 32'hCAFE_0001, 0, 4, NOP,           1'b1};
        tbl[7] = '{30'h31, 3, 1'b0, 32'hCAFE_0002, 0, 4, 32'hCAFE_0002, 1'b0};
        tbl[8] = '{30'h40, 0, 1'b0, 32'h5555_AAAA, 5, 1, 32'h5555_AAAA, 1'b0};
        tbl[9] = '{30'h41, 5, 1'b1, 32'h7777_0000, 2, 4, NOP,           1'b1};

        reset = 1'b1;
        step();
        step();
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'(NOP));
        chk("rst_pc", 64'(instr_pc), 64'd0);
        chk("rst_fault", 64'(instr_fault), 64'd0);
        chk("rst_stall", 64'(fetch_stall), 64'd1);
        reset = 1'b0;

        c0 = cycles;
        for (int i = 0; i < 10; i++) begin
            run_fetch(tbl[i].pc, tbl[i].lat, tbl[i].err, tbl[i].data, tbl[i].hold_n,
                      tbl[i].exp_reqs, tbl[i].exp_instr, tbl[i].exp_fault);
            if (i == 2) chk("zero_wait_cycles", 64'(cycles - c0), 64'd6);
        end

        // Reset during a pending fetch, with an ack landing in the reset cycle.
        pc = 30'h55;
        for (int k = 0; k < 3; k++) step();
        chk("mid_req_pending", 64'(imem_req), 64'd1);
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_err   = 1'b0;
        imem_rdata = 32'hFEED_FACE;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        step();
        reset    = 1'b0;
        imem_ack = 1'b0;
        pc       = 30'h66;
        #1;
        chk("post_rst_req", 64'(imem_req), 64'd1);
        chk("post_rst_addr", 64'(imem_addr), 64'h66);
        chk("post_rst_valid", 64'(instr_valid), 64'd0);
        chk("post_rst_instr", 64'(instr), 64'(NOP));
        chk("post_rst_pc", 64'(instr_pc), 64'd0);
        // Counter must have cleared: ack on the 4th request cycle still wins.
        run_fetch(30'h66, 3, 1'b0, 32'h6666_0066, 0, 4, 32'h6666_0066, 1'b0);

        for (int n = 0; n < 40; n++) begin
            lat = int'($urandom_range(0, 6));
            e   = ($urandom_range(0, 3) == 0);
            d   = $urandom;
            model(lat, e, d, er, ei, ef);
            run_fetch(30'($urandom), lat, e, d, int'($urandom_range(0, 3)), er, ei, ef);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register block.
- Takes the current word-address PC, issues a request/acknowledge read on the instruction-memory port, and registers the returned instruction for decode/execute.
- Drives a stall back to the PC block while a fetch is outstanding.
- Includes a bus-timeout watchdog and an access-fault flag.

Parameters:
- ADDR_WIDTH, 32: byte-address width. PC and memory address are word addresses of ADDR_WIDTH-2 bits.
- TIMEOUT, 255: max cycles in FETCH without ack before a fault is declared. 0 disables the watchdog.
- NOP_INSTR, 32'h0000_0013: instruction substituted on fault (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  reset
- pc  in  ADDR_WIDTH-2  current word PC from the PC block
- hold  in  1  stall from other sources (e.g. data memory); core does not advance
- imem_req  out  1  instruction read request
- imem_addr  out  ADDR_WIDTH-2  word address of the request
- imem_ack  in  1  read complete; imem_rdata/imem_err valid this cycle
- imem_rdata  in  32  returned instruction
- imem_err  in  1  bus error, qualified by imem_ack
- instr  out  32  registered instruction
- instr_pc  out  ADDR_WIDTH-2  PC the instruction was fetched from
- instr_valid  out  1  instr/instr_pc valid for execution
- instr_fault  out  1  instr is a substituted NOP due to bus error or timeout
- fetch_stall  out  1  to the PC block; system stall = fetch_stall | hold (ORed outside)

Behaviour:
- Reset is synchronous, active-high, on clk. Reset values:
  - state=FETCH, instr=NOP_INSTR, instr_pc=0, instr_valid=0, instr_fault=0, timeout count=0.
  - imem_req=0 in any cycle where reset is high.
- FSM has two states, FETCH and READY.
- FETCH:
  - imem_req=1 (unless reset), imem_addr=pc, fetch_stall=1, instr_valid=0.
  - pc is stable in FETCH because the PC block is stalled; imem_addr must not change while imem_req is high.
  - imem_ack=1, imem_err=0: instr<=imem_rdata, instr_pc<=pc, instr_fault<=0, go READY.
  - imem_ack=1, imem_err=1: instr<=NOP_INSTR, instr_pc<=pc, instr_fault<=1, go READY.
  - No ack, TIMEOUT!=0, count==TIMEOUT-1: same as error path; instr_fault<=1, go READY.
  - Otherwise count<=count+1.
  - Ack and timeout expiry in the same cycle: ack wins; its data is used with its own err.
  - Ack may arrive in the same cycle req first rises (zero-wait memory). Minimum fetch latency is 1 cycle: FETCH -> READY.
- READY:
  - imem_req=0, fetch_stall=0, instr_valid=1; instr, instr_pc and instr_fault held.
  - hold=0: the core consumes the instruction and the PC block advances this edge. Go FETCH, count<=0, instr_valid<=0.
  - hold=1: stay READY; all outputs unchanged.
  - An imem_ack seen while imem_req=0 is ignored (no state or data change).
- fetch_stall is decoded from registered state only; there is no combinational path from imem_ack to fetch_stall.
- instr_fault clears only when the next fetch completes cleanly.
- Reset mid-fetch: state returns to FETCH and count clears. An ack landing in the reset cycle is discarded. The request is reissued on the first cycle after reset using the post-reset pc.
- Counter width is clog2(TIMEOUT+1) and never wraps; with TIMEOUT=0 it stays at 0.
- Throughput: one instruction per 2 cycles with zero-wait memory (FETCH, READY).

Test Plan:
- Zero-wait memory, reset released with pc=0 and ack tied high -> cycle after reset: req=1, addr=0. Next cycle: instr_valid=1, instr=mem[0], instr_pc=0, fetch_stall=0. pc stepping 0,1,2 yields instr_pc 0,1,2 every 2 cycles.
- Ack delayed 3 cycles for pc=0x10 -> req and addr=0x10 held 4 cycles, fetch_stall=1 throughout. Then instr_valid=1 with instr=rdata and instr_pc=0x10.
- Bus error: ack=1, err=1 at pc=0x20 -> instr=0x0000_0013, instr_fault=1, instr_valid=1. Next clean fetch clears instr_fault to 0.
- Timeout with TIMEOUT=4 and no ack -> req high for exactly 4 cycles, then READY with instr=NOP and instr_fault=1. Repeat with ack on the 4th cycle -> real data, instr_fault=0.
- hold=1 for 5 cycles in READY -> instr/instr_pc/instr_valid stable, req=0. A spurious ack is ignored. After hold drops, FETCH on the next cycle.
- Reset asserted during a pending fetch with ack in the reset cycle -> no data latched, instr_valid=0, req=0 during reset. Fresh request issued on the cycle after reset.
